// File: rtl/sp_median_window.sv
// rtl/sp_median_window.sv - 5x5 impulse-noise filter: pipelined 3x3 median with 5x5 ring-mean fallback.
// Optional SP_NOISE_CNT_EN adds noise_cnt_o, a per-frame saturating count of noisy output pixels.
module sp_median_window #(
  parameter int DATADEPTH  = 12,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int NUM        = 5,
  parameter int LOW_TH     = 0,
  parameter int HIGH_TH    = 2**DATADEPTH-1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vsync_i,
  input  logic                     hsync_i,
  input  logic                     en_i,
  input  logic                     full_valid_i,
  input  logic [NUM*DATADEPTH-1:0] data_i,
  output logic [DATADEPTH-1:0]     data_o,
  output logic                     valid_o,
  output logic                     noise_o,
  output logic                     err_o
`ifdef SP_NOISE_CNT_EN
  ,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] noise_cnt_o
`endif
);

  localparam int D  = DATADEPTH;
  localparam int CW = $clog2(IMG_WIDTH+1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [D-1:0]  LO_PIX   = LOW_TH[D-1:0];
  localparam logic [D-1:0]  HI_PIX   = HIGH_TH[D-1:0];

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  // Only the 5-row geometry is implemented; other settings leave this marker block.
  if (NUM != 5 || IMG_WIDTH < 3 || IMG_HEIGHT < 1) begin : g_unsupported_cfg
  end

  function automatic logic [D-1:0] mn(input logic [D-1:0] a, input logic [D-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [D-1:0] mx(input logic [D-1:0] a, input logic [D-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [D-1:0] md(input logic [D-1:0] a, input logic [D-1:0] b,
                                      input logic [D-1:0] c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  // Packed as {hi, mid, lo}.
  function automatic logic [3*D-1:0] sort3(input logic [D-1:0] a, input logic [D-1:0] b,
                                           input logic [D-1:0] c);
    return {mx(mx(a, b), c), md(a, b, c), mn(mn(a, b), c)};
  endfunction

  function automatic logic is_noisy(input logic [D-1:0] p);
    return (p <= LO_PIX) || (p >= HI_PIX);
  endfunction

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic                 flush_ph;
  logic                 line_fv;
  logic                 win_vld;
  logic [NUM*D-1:0]     win [5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      flush_ph <= 1'b0;
      line_fv  <= 1'b0;
      win_vld  <= 1'b0;
      err_o    <= 1'b0;
      for (int i = 0; i < 5; i++) win[i] <= '0;
    end else begin
      win_vld <= 1'b0;
      if (vsync_i) begin
        state <= IDLE;
        err_o <= 1'b0;
      end else if (en_i && hsync_i) begin
        // A line start outside IDLE abandons the current line.
        if (state != IDLE) err_o <= 1'b1;
        for (int i = 0; i < 5; i++) win[i] <= data_i;
        cnt     <= CW'(1);
        line_fv <= full_valid_i;
        state   <= FILL;
      end else if (state == FLUSH) begin
        for (int i = 0; i < 4; i++) win[i] <= win[i+1];
        win_vld  <= 1'b1;
        flush_ph <= ~flush_ph;
        if (flush_ph) state <= IDLE;
      end else if (en_i && (state == FILL || state == RUN)) begin
        for (int i = 0; i < 4; i++) win[i] <= win[i+1];
        win[4] <= data_i;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST_COL) begin
          state    <= FLUSH;
          flush_ph <= 1'b0;
          win_vld  <= 1'b1;
        end else if (cnt >= COL_TWO) begin
          state   <= RUN;
          win_vld <= 1'b1;
        end
      end
    end
  end

  logic [D+1:0] ring_sum;
  always_comb begin
    ring_sum = {2'b00, win[0][2*D +: D]} + {2'b00, win[4][2*D +: D]}
             + {2'b00, win[2][0 +: D]}   + {2'b00, win[2][4*D +: D]};
  end

  logic [3*D-1:0] s1_srt [3];
  logic [D-1:0]   s1_ctr, s1_ring, s2_a, s2_b, s2_c, s2_ctr, s2_ring;
  logic           s1_vld, s1_fv, s2_vld, s2_fv;
  logic [D-1:0]   med9;

  always_comb begin
    med9 = md(s2_a, s2_b, s2_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) s1_srt[k] <= '0;
      {s1_ctr, s1_ring, s1_vld, s1_fv} <= '0;
      {s2_a, s2_b, s2_c, s2_ctr, s2_ring, s2_vld, s2_fv} <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      noise_o <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        s1_srt[k] <= sort3(win[k+1][D +: D], win[k+1][2*D +: D], win[k+1][3*D +: D]);
      s1_ctr  <= win[2][2*D +: D];
      s1_ring <= ring_sum[D+1:2];
      s1_vld  <= win_vld;
      s1_fv   <= line_fv;

      s2_a    <= mx(mx(s1_srt[0][0 +: D], s1_srt[1][0 +: D]), s1_srt[2][0 +: D]);
      s2_b    <= md(s1_srt[0][D +: D], s1_srt[1][D +: D], s1_srt[2][D +: D]);
      s2_c    <= mn(mn(s1_srt[0][2*D +: D], s1_srt[1][2*D +: D]), s1_srt[2][2*D +: D]);
      s2_ctr  <= s1_ctr;
      s2_ring <= s1_ring;
      s2_vld  <= s1_vld;
      s2_fv   <= s1_fv;

      valid_o <= s2_vld;
      noise_o <= 1'b0;
      if (s2_vld) begin
        if (!s2_fv || !is_noisy(s2_ctr)) begin
          data_o <= s2_ctr;
        end else if (!is_noisy(med9)) begin
          data_o  <= med9;
          noise_o <= 1'b1;
        end else begin
          data_o  <= s2_ring;
          noise_o <= 1'b1;
        end
      end
    end
  end

`ifdef SP_NOISE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || vsync_i) begin
      noise_cnt_o <= '0;
    end else if (valid_o && noise_o && !(&noise_cnt_o)) begin
      noise_cnt_o <= noise_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sp_median_window.sv
// tb/tb_sp_median_window.sv - directed and randomized bench for sp_median_window with a sort-based model.
// Covers SP_NOISE_CNT_EN when that macro is defined.
module tb_sp_median_window;

  localparam int D = 12;
  localparam int W = 8;
  localparam int H = 4;

  logic           clk = 1'b0;
  logic           rst, vsync_i, hsync_i, en_i, full_valid_i;
  logic [5*D-1:0] data_i;
  logic [D-1:0]   data_o;
  logic           valid_o, noise_o, err_o;
`ifdef SP_NOISE_CNT_EN
  logic [$clog2(W*H+1)-1:0] noise_cnt_o;
`endif

  sp_median_window #(.DATADEPTH(D), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .vsync_i(vsync_i), .hsync_i(hsync_i), .en_i(en_i),
    .full_valid_i(full_valid_i), .data_i(data_i), .data_o(data_o),
    .valid_o(valid_o), .noise_o(noise_o), .err_o(err_o)
`ifdef SP_NOISE_CNT_EN
    , .noise_cnt_o(noise_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          noise_exp = 0;
  int          first_t, last_t;
  int          img [W][5];
  logic [12:0] act_q [$];
  int          act_t [$];
  logic [12:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      act_q.push_back({noise_o, data_o});
      act_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int px(int r, int c);
    if (c < 0) c = 0;
    if (c > W-1) c = W-1;
    return img[c][r];
  endfunction

  function automatic bit noisy(int v);
    return (v <= 0) || (v >= 4095);
  endfunction

  function automatic logic [12:0] expect_col(int x, bit fv);
    int v [$];
    int ctr, med, ring;
    ctr = px(2, x);
    for (int r = 1; r <= 3; r++)
      for (int c = x-1; c <= x+1; c++) v.push_back(px(r, c));
    v.sort();
    med  = v[4];
    ring = (px(2, x-2) + px(2, x+2) + px(0, x) + px(4, x)) / 4;
    if (!fv || !noisy(ctr)) return {1'b0, 12'(ctr)};
    if (!noisy(med))        return {1'b1, 12'(med)};
    return {1'b1, 12'(ring)};
  endfunction

  task automatic build_exp(input int n, input bit fv);
    logic [12:0] e;
    for (int x = 0; x < n; x++) begin
      e = expect_col(x, fv);
      exp_q.push_back(e);
      if (e[12]) noise_exp++;
    end
  endtask

  task automatic send_cols(input bit fv, input bit gaps, output int t2, output int tl);
    t2 = 0;
    tl = 0;
    for (int x = 0; x < W; x++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      en_i = 1'b1;
      hsync_i = (x == 0);
      full_valid_i = fv;
      for (int r = 0; r < 5; r++) data_i[r*D +: D] = D'(img[x][r]);
      step();
      if (x == 2) t2 = cyc;
      if (x == W-1) tl = cyc;
      en_i = 1'b0;
      hsync_i = 1'b0;
    end
  endtask

  task automatic check_outs(input string tag);
    int k = 0;
    while (act_q.size() < exp_q.size() && k < 60) begin
      step();
      k++;
    end
    repeat (4) step();
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), int'(act_q[i][11:0]), int'(exp_q[i][11:0]));
      chk($sformatf("%s_noise%0d", tag, i), int'(act_q[i][12]), int'(exp_q[i][12]));
    end
    first_t = (act_t.size() > 0) ? act_t[0] : -100;
    last_t  = (act_t.size() > 0) ? act_t[act_t.size()-1] : -100;
    act_q.delete();
    act_t.delete();
    exp_q.delete();
  endtask

  task automatic fill_img(input int lo, input int hi);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < 5; r++) img[c][r] = $urandom_range(hi, lo);
  endtask

  initial begin
    int t2, tl;
    rst = 1'b1; vsync_i = 1'b0; hsync_i = 1'b0; en_i = 1'b0; full_valid_i = 1'b0; data_i = '0;
    repeat (3) step();
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_noise", int'(noise_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst = 1'b0;
    step();

    // Flat line: pass-through and latency.
    fill_img(100, 100);
    build_exp(W, 1'b1);
    send_cols(1'b1, 1'b0, t2, tl);
    check_outs("flat");
    chk("lat_first", first_t - t2, 3);
    chk("lat_last", last_t - tl, 5);
    chk("flat_err", int'(err_o), 0);

    // Salt spike on centre column 4.
    fill_img(100, 108);
    img[4][2] = 4095;
    build_exp(W, 1'b1);
    send_cols(1'b1, 1'b1, t2, tl);
    check_outs("spike");

    // Whole 3x3 block zero: ring-mean fallback.
    fill_img(300, 300);
    for (int c = 3; c <= 5; c++)
      for (int r = 1; r <= 3; r++) img[c][r] = 0;
    img[2][2] = 200; img[6][2] = 400; img[4][0] = 600; img[4][4] = 800;
    build_exp(W, 1'b1);
    chk("ring_model", int'(exp_q[4][11:0]), 500);
    send_cols(1'b1, 1'b0, t2, tl);
    check_outs("ring");
`ifdef SP_NOISE_CNT_EN
    chk("noise_cnt", int'(noise_cnt_o), noise_exp);
`endif

    // Vertical border line: noisy centres pass through.
    fill_img(1, 4094);
    for (int c = 0; c < W; c++) img[c][2] = 0;
    build_exp(W, 1'b0);
    send_cols(1'b0, 1'b1, t2, tl);
    check_outs("border");

    // Randomized lines with injected salt and pepper.
    for (int n = 0; n < 6; n++) begin
      bit fv;
      fv = ($urandom_range(0, 3) != 0);
      fill_img(1, 4094);
      for (int c = 0; c < W; c++)
        for (int r = 0; r < 5; r++)
          if ($urandom_range(0, 2) == 0) img[c][r] = ($urandom_range(0, 1) == 1) ? 4095 : 0;
      build_exp(W, fv);
      send_cols(fv, 1'b1, t2, tl);
      check_outs($sformatf("rand%0d", n));
    end

    // New line one cycle into FLUSH: old line truncated to W-1 outputs.
    fill_img(1, 4094);
    img[3][2] = 0;
    build_exp(W-1, 1'b1);
    send_cols(1'b1, 1'b0, t2, tl);
    step();
    fill_img(1, 4094);
    img[5][2] = 4095;
    build_exp(W, 1'b1);
    send_cols(1'b1, 1'b0, t2, tl);
    chk("err_set", int'(err_o), 1);
    check_outs("restart");
    chk("err_sticky", int'(err_o), 1);

    vsync_i = 1'b1;
    step();
    vsync_i = 1'b0;
    noise_exp = 0;
    chk("err_vsync", int'(err_o), 0);
`ifdef SP_NOISE_CNT_EN
    chk("noise_cnt_vsync", int'(noise_cnt_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
